// File: rtl/sap1_pkg.sv
// rtl/sap1_pkg.sv - shared constants, control ROM and default memory image for the SAP-1 CPU
package sap1_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int CW_W   = 18;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [ADDR_W-1:0] UA_FETCH = 4'd0;
    localparam logic [ADDR_W-1:0] UA_LDA   = 4'd4;
    localparam logic [ADDR_W-1:0] UA_ADD   = 4'd6;
    localparam logic [ADDR_W-1:0] UA_SUB   = 4'd10;
    localparam logic [ADDR_W-1:0] UA_OUT   = 4'd14;
    localparam logic [ADDR_W-1:0] UA_HLT   = 4'd15;

    localparam int CW_EP = 17, CW_CP = 16, CW_SELECT = 15, CW_LM = 14, CW_CE = 13, CW_LI = 12;
    localparam int CW_EI = 11, CW_CS = 10, CW_LOAD = 9, CW_CLR = 8, CW_INC = 7, CW_SELECT_ACC = 6;
    localparam int CW_LA = 5, CW_EA = 4, CW_LB = 3, CW_SU = 2, CW_EU = 1, CW_LO = 0;

    localparam logic [CW_W-1:0] M_EP  = CW_W'(1) << CW_EP;
    localparam logic [CW_W-1:0] M_CP  = CW_W'(1) << CW_CP;
    localparam logic [CW_W-1:0] M_SEL = CW_W'(1) << CW_SELECT;
    localparam logic [CW_W-1:0] M_LM  = CW_W'(1) << CW_LM;
    localparam logic [CW_W-1:0] M_CE  = CW_W'(1) << CW_CE;
    localparam logic [CW_W-1:0] M_LI  = CW_W'(1) << CW_LI;
    localparam logic [CW_W-1:0] M_EI  = CW_W'(1) << CW_EI;
    localparam logic [CW_W-1:0] M_CS  = CW_W'(1) << CW_CS;
    localparam logic [CW_W-1:0] M_LD  = CW_W'(1) << CW_LOAD;
    localparam logic [CW_W-1:0] M_CLR = CW_W'(1) << CW_CLR;
    localparam logic [CW_W-1:0] M_INC = CW_W'(1) << CW_INC;
    localparam logic [CW_W-1:0] M_SA  = CW_W'(1) << CW_SELECT_ACC;
    localparam logic [CW_W-1:0] M_LA  = CW_W'(1) << CW_LA;
    localparam logic [CW_W-1:0] M_EA  = CW_W'(1) << CW_EA;
    localparam logic [CW_W-1:0] M_LB  = CW_W'(1) << CW_LB;
    localparam logic [CW_W-1:0] M_SU  = CW_W'(1) << CW_SU;
    localparam logic [CW_W-1:0] M_EU  = CW_W'(1) << CW_EU;
    localparam logic [CW_W-1:0] M_LO  = CW_W'(1) << CW_LO;

    // Steps 0-3 are the shared fetch; each opcode routine ends with CLR back to fetch.
    localparam logic [CW_W-1:0] CTRL_ROM [16] = '{
        M_EP | M_LM | M_INC,
        M_CP | M_INC,
        M_CS | M_CE | M_LI | M_INC,
        M_LD,
        M_EI | M_SEL | M_LM | M_INC,
        M_CS | M_CE | M_LA | M_CLR,
        M_EI | M_SEL | M_LM | M_INC,
        M_CS | M_CE | M_LB | M_INC,
        M_EU | M_SA | M_LA | M_INC,
        M_CLR,
        M_EI | M_SEL | M_LM | M_INC,
        M_CS | M_CE | M_LB | M_INC,
        M_SU | M_EU | M_SA | M_LA | M_INC,
        M_CLR,
        M_EA | M_LO | M_CLR,
        '0
    };

    // Word i lives at bits [8*i +: 8].
    localparam logic [16*DATA_W-1:0] DEFAULT_MEM = 128'h00000020_18141000_000000F0_E01B1A09;

    function automatic logic [ADDR_W-1:0] op_map(input logic [3:0] op);
        case (op)
            OP_LDA:  return UA_LDA;
            OP_ADD:  return UA_ADD;
            OP_SUB:  return UA_SUB;
            OP_OUT:  return UA_OUT;
            OP_HLT:  return UA_HLT;
            default: return UA_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/sap1_ctrl_seq.sv
// rtl/sap1_ctrl_seq.sv - micro-PC sequencer with control ROM and opcode map
import sap1_pkg::*;

module sap1_ctrl_seq (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        opcode,
    output logic [ADDR_W-1:0] upc,
    output logic [CW_W-1:0]   cw
);

    logic [ADDR_W-1:0] upc_next;

    assign cw = CTRL_ROM[upc];

    always_comb begin
        upc_next = upc;
        if (cw[CW_CLR])
            upc_next = UA_FETCH;
        else if (cw[CW_LOAD])
            upc_next = op_map(opcode);
        else if (cw[CW_INC])
            upc_next = upc + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            upc <= '0;
        else
            upc <= upc_next;
    end

endmodule

// File: rtl/sap1_hmicro_cpu.sv
// rtl/sap1_hmicro_cpu.sv - SAP-1 datapath with horizontal microprogrammed control
import sap1_pkg::*;

module sap1_hmicro_cpu #(
    parameter logic [16*DATA_W-1:0] MEM_IMAGE = DEFAULT_MEM
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] PC_OUT,
    output logic [ADDR_W-1:0] MAR_OUT,
    output logic [3:0]        IR_OUT1,
    output logic [3:0]        IR_OUT2,
    output logic [DATA_W-1:0] DATA_OUT1,
    output logic [ADDR_W-1:0] ADDR_OUT1,
    output logic [ADDR_W-1:0] COUNT_OUT,
    output logic [DATA_W-1:0] ACCUMULATOR_OUT,
    output logic [DATA_W-1:0] DATA_OUTPUT,
    output logic [DATA_W-1:0] B_REG,
    output logic [DATA_W-1:0] ALU_OUT,
    output logic [DATA_W-1:0] OR_out,
    output logic [CW_W-1:0]   CW,
    output logic EP, output logic CP, output logic SELECT, output logic LM,
    output logic CE, output logic LI, output logic EI, output logic CS,
    output logic LOAD, output logic CLR, output logic INC, output logic SELECT_ACC,
    output logic LA, output logic EA, output logic LB, output logic SU,
    output logic EU, output logic LO
);

    logic [ADDR_W-1:0] pc, mar;
    logic [DATA_W-1:0] ir, a, b, out_reg, mem_word;
    logic              mem_en;

    sap1_ctrl_seq u_seq (
        .clk    (clk),
        .rst    (rst),
        .opcode (ir[7:4]),
        .upc    (COUNT_OUT),
        .cw     (CW)
    );

    assign {EP, CP, SELECT, LM, CE, LI, EI, CS, LOAD, CLR, INC, SELECT_ACC,
            LA, EA, LB, SU, EU, LO} = CW;

    assign mem_word    = MEM_IMAGE[32'(mar) * DATA_W +: DATA_W];
    assign mem_en      = CS & CE;
    assign DATA_OUT1   = mem_word;
    assign DATA_OUTPUT = mem_en ? mem_word : '0;
    assign ADDR_OUT1   = SELECT ? ir[3:0] : pc;
    assign ALU_OUT     = SU ? (a - b) : (a + b);

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc      <= '0;
            mar     <= '0;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            out_reg <= '0;
        end else begin
            if (CP)
                pc <= pc + 4'd1;
            if (LM & (EP | EI))
                mar <= ADDR_OUT1;
            if (LI & mem_en)
                ir <= mem_word;
            if (LB & mem_en)
                b <= mem_word;
            // A takes either the ALU result or a memory word, each path with its own enable.
            if (LA & SELECT_ACC & EU)
                a <= ALU_OUT;
            else if (LA & ~SELECT_ACC & mem_en)
                a <= mem_word;
            if (LO & EA)
                out_reg <= a;
        end
    end

    assign PC_OUT          = pc;
    assign MAR_OUT         = mar;
    assign IR_OUT1         = ir[7:4];
    assign IR_OUT2         = ir[3:0];
    assign ACCUMULATOR_OUT = a;
    assign B_REG           = b;
    assign OR_out          = out_reg;

endmodule

// File: tb/tb_sap1_hmicro_cpu.sv
// tb/tb_sap1_hmicro_cpu.sv - scoreboard bench running the default and a patched program image
module tb_sap1_hmicro_cpu;

    localparam logic [127:0] PATCH_MEM = 128'h50505020_50503050_50505050_50E0290C;
    localparam int S_PC = 0, S_MAR = 1, S_IR = 2, S_A = 3, S_B = 4, S_OR = 5, S_UPC = 6, S_CW = 7, S_ALU = 8;

    logic clk = 1'b0;
    logic [1:0] rst;

    logic [1:0][3:0]  pc, mar, ir_hi, ir_lo, addr, upc;
    logic [1:0][7:0]  dout1, acc, dout, breg, alu, oreg;
    logic [1:0][17:0] cw, bits;

    typedef struct {
        string       name;
        int          d;
        int          s;
        logic [17:0] exp;
    } exp_t;

    exp_t        sbq[$];
    exp_t        e;
    logic [17:0] act;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    sap1_hmicro_cpu u_dut0 (
        .clk(clk), .rst(rst[0]), .PC_OUT(pc[0]), .MAR_OUT(mar[0]), .IR_OUT1(ir_hi[0]), .IR_OUT2(ir_lo[0]),
        .DATA_OUT1(dout1[0]), .ADDR_OUT1(addr[0]), .COUNT_OUT(upc[0]), .ACCUMULATOR_OUT(acc[0]),
        .DATA_OUTPUT(dout[0]), .B_REG(breg[0]), .ALU_OUT(alu[0]), .OR_out(oreg[0]), .CW(cw[0]),
        .EP(bits[0][17]), .CP(bits[0][16]), .SELECT(bits[0][15]), .LM(bits[0][14]), .CE(bits[0][13]),
        .LI(bits[0][12]), .EI(bits[0][11]), .CS(bits[0][10]), .LOAD(bits[0][9]), .CLR(bits[0][8]),
        .INC(bits[0][7]), .SELECT_ACC(bits[0][6]), .LA(bits[0][5]), .EA(bits[0][4]), .LB(bits[0][3]),
        .SU(bits[0][2]), .EU(bits[0][1]), .LO(bits[0][0])
    );

    sap1_hmicro_cpu #(.MEM_IMAGE(PATCH_MEM)) u_dut1 (
        .clk(clk), .rst(rst[1]), .PC_OUT(pc[1]), .MAR_OUT(mar[1]), .IR_OUT1(ir_hi[1]), .IR_OUT2(ir_lo[1]),
        .DATA_OUT1(dout1[1]), .ADDR_OUT1(addr[1]), .COUNT_OUT(upc[1]), .ACCUMULATOR_OUT(acc[1]),
        .DATA_OUTPUT(dout[1]), .B_REG(breg[1]), .ALU_OUT(alu[1]), .OR_out(oreg[1]), .CW(cw[1]),
        .EP(bits[1][17]), .CP(bits[1][16]), .SELECT(bits[1][15]), .LM(bits[1][14]), .CE(bits[1][13]),
        .LI(bits[1][12]), .EI(bits[1][11]), .CS(bits[1][10]), .LOAD(bits[1][9]), .CLR(bits[1][8]),
        .INC(bits[1][7]), .SELECT_ACC(bits[1][6]), .LA(bits[1][5]), .EA(bits[1][4]), .LB(bits[1][3]),
        .SU(bits[1][2]), .EU(bits[1][1]), .LO(bits[1][0])
    );

    function automatic logic [17:0] get_sig(input int d, input int s);
        case (s)
            S_PC:    return 18'(pc[d]);
            S_MAR:   return 18'(mar[d]);
            S_IR:    return 18'({ir_hi[d], ir_lo[d]});
            S_A:     return 18'(acc[d]);
            S_B:     return 18'(breg[d]);
            S_OR:    return 18'(oreg[d]);
            S_UPC:   return 18'(upc[d]);
            S_CW:    return cw[d];
            default: return 18'(alu[d]);
        endcase
    endfunction

    // Monitor: drains every expectation queued since the last rising edge.
    always @(negedge clk) begin
        while (sbq.size() > 0) begin
            e   = sbq.pop_front();
            act = get_sig(e.d, e.s);
            n_checks++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s (dut%0d): got 0x%0h expected 0x%0h", e.name, e.d, act, e.exp);
            end
        end
    end

    task automatic expect_sig(input string nm, input int d, input int s, input logic [17:0] v);
        sbq.push_back('{nm, d, s, v});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_zero(input string nm, input int d);
        expect_sig({nm, "_pc"}, d, S_PC, 0);
        expect_sig({nm, "_mar"}, d, S_MAR, 0);
        expect_sig({nm, "_ir"}, d, S_IR, 0);
        expect_sig({nm, "_a"}, d, S_A, 0);
        expect_sig({nm, "_b"}, d, S_B, 0);
        expect_sig({nm, "_or"}, d, S_OR, 0);
        expect_sig({nm, "_upc"}, d, S_UPC, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 2'b00;
        tick(1);
        expect_zero("reset", 0);
        expect_sig("reset_cw", 0, S_CW, 18'h24080);
        rst[0] = 1'b1;

        tick(6);
        expect_sig("lda_ir", 0, S_IR, 8'h09);
        expect_sig("lda_mar", 0, S_MAR, 9);
        expect_sig("lda_a", 0, S_A, 8'h10);
        expect_sig("lda_pc", 0, S_PC, 1);
        expect_sig("lda_upc", 0, S_UPC, 0);

        tick(6);
        expect_sig("add_step8_upc", 0, S_UPC, 8);
        expect_sig("add_step8_cw", 0, S_CW, 18'h000E2);
        expect_sig("add_step8_alu", 0, S_ALU, 8'h24);
        tick(2);
        expect_sig("adda_a", 0, S_A, 8'h24);
        expect_sig("adda_b", 0, S_B, 8'h14);
        tick(8);
        expect_sig("addb_a", 0, S_A, 8'h3C);
        expect_sig("addb_b", 0, S_B, 8'h18);
        expect_sig("addb_pc", 0, S_PC, 3);

        tick(5);
        expect_sig("out_or", 0, S_OR, 8'h3C);
        tick(4);
        expect_sig("hlt_upc", 0, S_UPC, 15);
        tick(10);
        expect_sig("hlt_pc", 0, S_PC, 5);
        expect_sig("hlt_mar", 0, S_MAR, 4);
        expect_sig("hlt_ir", 0, S_IR, 8'hF0);
        expect_sig("hlt_a", 0, S_A, 8'h3C);
        expect_sig("hlt_or", 0, S_OR, 8'h3C);
        expect_sig("hlt_upc_hold", 0, S_UPC, 15);
        expect_sig("hlt_cw", 0, S_CW, 0);

        rst[0] = 1'b0;
        tick(1);
        expect_zero("rst2", 0);
        rst[0] = 1'b1;
        tick(11);
        expect_sig("midop_upc", 0, S_UPC, 7);
        expect_sig("midop_mar", 0, S_MAR, 4'hA);
        rst[0] = 1'b0;
        tick(1);
        expect_zero("midop_rst", 0);
        rst[0] = 1'b1;
        tick(6);
        expect_sig("rerun_a", 0, S_A, 8'h10);
        expect_sig("rerun_pc", 0, S_PC, 1);
        expect_sig("rerun_ir", 0, S_IR, 8'h09);

        rst[1] = 1'b1;
        tick(6);
        expect_sig("p_lda_a", 1, S_A, 8'h20);
        tick(8);
        expect_sig("p_sub_a", 1, S_A, 8'hF0);
        expect_sig("p_sub_b", 1, S_B, 8'h30);
        expect_sig("p_sub_pc", 1, S_PC, 2);
        tick(5);
        expect_sig("p_out_or", 1, S_OR, 8'hF0);
        tick(56);
        expect_sig("p_wrap_pc", 1, S_PC, 0);
        expect_sig("p_wrap_a", 1, S_A, 8'hE4);
        expect_sig("p_wrap_b", 1, S_B, 8'h0C);
        expect_sig("p_wrap_upc", 1, S_UPC, 0);

        @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
